// File: rtl/sdp_bram_multi.sv
// sdp_bram_multi: NCH independent simple-dual-port block RAMs with per-lane byte
// enables, a post-reset clear sequencer and write-first read/write collisions.
// Define BRAM_OUTREG_EN to add one extra output register stage per channel
// (read latency 2 instead of 1, rvalid delayed to stay aligned with rd).

module sdp_bram_multi #(
    parameter int ABITS     = 10,
    parameter int DBITS     = 36,
    parameter int BYTEWIDTH = 9,
    parameter int NCH       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NCH*ABITS-1:0]          ra,
    input  logic [NCH-1:0]                re,
    output logic [NCH*DBITS-1:0]          rd,
    output logic [NCH-1:0]                rvalid,
    input  logic [NCH*ABITS-1:0]          wa,
    input  logic [NCH*DBITS-1:0]          wd,
    input  logic [NCH-1:0]                we,
    input  logic [NCH*(DBITS/BYTEWIDTH)-1:0] be,
    output logic                          busy
);

    localparam int DEPTH  = 2**ABITS;
    localparam int NBYTES = DBITS / BYTEWIDTH;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t           state;
    logic [ABITS-1:0] cnt;

    logic [DBITS-1:0] rd_ch [NCH];
    logic             rv_ch [NCH];

    // Clear sequencer: sweep every address once after reset, then hand over to normal operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == ABITS'(DEPTH - 1)) begin
                state <= RUN;
                busy  <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        (* syn_ramstyle = "block_ram" *) logic [DBITS-1:0] mem [DEPTH];

        logic [ABITS-1:0]  ra_c;
        logic [ABITS-1:0]  wa_c;
        logic [DBITS-1:0]  wd_c;
        logic [NBYTES-1:0] be_c;
        logic [DBITS-1:0]  wmask;
        logic [DBITS-1:0]  colmask;
        logic [DBITS-1:0]  rd1;
        logic              rv1;

        assign ra_c = ra[c*ABITS +: ABITS];
        assign wa_c = wa[c*ABITS +: ABITS];
        assign wd_c = wd[c*DBITS +: DBITS];
        assign be_c = be[c*NBYTES +: NBYTES];

        // Expand byte enables to a bit mask; the collision mask only applies when addresses match
        always_comb begin
            wmask   = '0;
            colmask = '0;
            for (int i = 0; i < NBYTES; i++) begin
                wmask[i*BYTEWIDTH +: BYTEWIDTH] = {BYTEWIDTH{be_c[i]}};
            end
            if (we[c] && (wa_c == ra_c)) begin
                colmask = wmask;
            end
        end

        // Memory write port: zero fill during the clear sweep, masked byte writes afterwards
        always_ff @(posedge clk) begin
            if (rst_n) begin
                if (state == CLEAR) begin
                    mem[cnt] <= '0;
                end else if (we[c]) begin
                    mem[wa_c] <= (mem[wa_c] & ~wmask) | (wd_c & wmask);
                end
            end
        end

        // Read port: registered data with write-first bypass of the enabled lanes on a collision
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd1 <= '0;
                rv1 <= 1'b0;
            end else if ((state == RUN) && re[c]) begin
                rd1 <= (mem[ra_c] & ~colmask) | (wd_c & colmask);
                rv1 <= 1'b1;
            end else begin
                rv1 <= 1'b0;
            end
        end

`ifdef BRAM_OUTREG_EN
        logic [DBITS-1:0] rd2;
        logic             rv2;

        // Extra output stage: captures read data only when a fresh value arrives
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd2 <= '0;
                rv2 <= 1'b0;
            end else begin
                rv2 <= rv1;
                if (rv1) begin
                    rd2 <= rd1;
                end
            end
        end

        assign rd_ch[c] = rd2;
        assign rv_ch[c] = rv2;
`else
        assign rd_ch[c] = rd1;
        assign rv_ch[c] = rv1;
`endif
    end

    // Pack per-channel results onto the flat output buses
    always_comb begin
        rd     = '0;
        rvalid = '0;
        for (int c = 0; c < NCH; c++) begin
            rd[c*DBITS +: DBITS] = rd_ch[c];
            rvalid[c]            = rv_ch[c];
        end
    end

endmodule

// File: tb/tb_sdp_bram_multi.sv
// tb_sdp_bram_multi: directed and randomized checks of sdp_bram_multi against a
// behavioural model (ABITS=4, DBITS=16, BYTEWIDTH=8, NCH=2).

module tb_sdp_bram_multi;

    localparam int ABITS = 4;
    localparam int DBITS = 16;
    localparam int BW    = 8;
    localparam int NCH   = 2;
    localparam int DEPTH = 16;
`ifdef BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ra;
    logic [1:0]  re;
    logic [31:0] rd;
    logic [1:0]  rvalid;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [1:0]  we;
    logic [3:0]  be;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] refMem [NCH][DEPTH];
    int          clearLeft = 0;
    int          clearAddr = 0;
    logic [15:0] s1Rd [NCH];
    logic        s1Rv [NCH];
    logic [15:0] s2Rd [NCH];
    logic        s2Rv [NCH];

    sdp_bram_multi #(
        .ABITS(ABITS),
        .DBITS(DBITS),
        .BYTEWIDTH(BW),
        .NCH(NCH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ra(ra),
        .re(re),
        .rd(rd),
        .rvalid(rvalid),
        .wa(wa),
        .wd(wd),
        .we(we),
        .be(be),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic modelEdge();
        logic [3:0]  r;
        logic [3:0]  w;
        logic [15:0] d;
        logic [15:0] old;
        if (!rst_n) begin
            clearLeft = DEPTH;
            clearAddr = 0;
            for (int c = 0; c < NCH; c++) begin
                s1Rd[c] = '0; s1Rv[c] = 1'b0;
                s2Rd[c] = '0; s2Rv[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (s1Rv[c]) s2Rd[c] = s1Rd[c];
                s2Rv[c] = s1Rv[c];
            end
            if (clearLeft > 0) begin
                for (int c = 0; c < NCH; c++) begin
                    refMem[c][clearAddr] = 16'h0000;
                    s1Rv[c] = 1'b0;
                end
                clearAddr++;
                clearLeft--;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    r   = ra[c*4 +: 4];
                    w   = wa[c*4 +: 4];
                    d   = wd[c*16 +: 16];
                    old = refMem[c][r];
                    if (re[c]) begin
                        s1Rd[c] = old;
                        for (int i = 0; i < 2; i++) begin
                            if (we[c] && (r == w) && be[c*2 + i])
                                s1Rd[c][i*8 +: 8] = d[i*8 +: 8];
                        end
                        s1Rv[c] = 1'b1;
                    end else begin
                        s1Rv[c] = 1'b0;
                    end
                    if (we[c]) begin
                        for (int i = 0; i < 2; i++) begin
                            if (be[c*2 + i]) refMem[c][w][i*8 +: 8] = d[i*8 +: 8];
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [15:0] expRd(input int c);
`ifdef BRAM_OUTREG_EN
        return s2Rd[c];
`else
        return s1Rd[c];
`endif
    endfunction

    function automatic logic expRv(input int c);
`ifdef BRAM_OUTREG_EN
        return s2Rv[c];
`else
        return s1Rv[c];
`endif
    endfunction

    task automatic checkOutput();
        checkValue("busy", {31'd0, busy}, {31'd0, clearLeft > 0});
        checkValue("rvalid0", {31'd0, rvalid[0]}, {31'd0, expRv(0)});
        checkValue("rvalid1", {31'd0, rvalid[1]}, {31'd0, expRv(1)});
        checkValue("rd0", {16'd0, rd[15:0]}, {16'd0, expRd(0)});
        checkValue("rd1", {16'd0, rd[31:16]}, {16'd0, expRd(1)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        modelEdge();
        checkOutput();
    endtask

    task automatic applyStimulus(input int ch, input logic r, input logic [3:0] raddr,
                                 input logic w, input logic [3:0] waddr,
                                 input logic [15:0] data, input logic [1:0] bytes);
        re[ch]          = r;
        ra[ch*4 +: 4]   = raddr;
        we[ch]          = w;
        wa[ch*4 +: 4]   = waddr;
        wd[ch*16 +: 16] = data;
        be[ch*2 +: 2]   = bytes;
    endtask

    task automatic idle();
        re = '0;
        we = '0;
        be = '0;
    endtask

    task automatic waitClear(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checkValue(tag, n, 16);
    endtask

    initial begin
        rst_n = 1'b0;
        ra = '0; wa = '0; wd = '0;
        idle();

        $display("[TB] reset and clear");
        step();
        step();
        checkValue("resetBusy", {31'd0, busy}, 32'd1);
        checkValue("resetRvalid", {30'd0, rvalid}, 32'd0);
        rst_n = 1'b1;
        waitClear("clearLength");

        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(0, 1'b1, 4'(a), 1'b0, 4'd0, 16'h0, 2'b00);
            applyStimulus(1, 1'b1, 4'(a), 1'b0, 4'd0, 16'h0, 2'b00);
            step();
        end
        idle();
        repeat (LAT) step();
        checkValue("clearReadAll", rd, 32'h0);

        $display("[TB] byte enable");
        applyStimulus(0, 1'b0, 4'd0, 1'b1, 4'd3, 16'hABCD, 2'b11);
        step();
        applyStimulus(0, 1'b0, 4'd0, 1'b1, 4'd3, 16'h1234, 2'b01);
        step();
        applyStimulus(0, 1'b0, 4'd0, 1'b1, 4'd3, 16'hFFFF, 2'b00);
        step();
        applyStimulus(0, 1'b1, 4'd3, 1'b0, 4'd0, 16'h0, 2'b00);
        applyStimulus(1, 1'b1, 4'd3, 1'b0, 4'd0, 16'h0, 2'b00);
        step();
        idle();
        repeat (LAT - 1) step();
        checkValue("byteEnRd0", {16'd0, rd[15:0]}, 32'h0000AB34);
        checkValue("byteEnRv0", {31'd0, rvalid[0]}, 32'd1);
        checkValue("byteEnCh1", {16'd0, rd[31:16]}, 32'h0);
        step();
        checkValue("pulseEnd", {31'd0, rvalid[0]}, 32'd0);
        checkValue("rdHold", {16'd0, rd[15:0]}, 32'h0000AB34);

        $display("[TB] collision");
        applyStimulus(1, 1'b0, 4'd0, 1'b1, 4'd7, 16'h5555, 2'b11);
        step();
        applyStimulus(1, 1'b1, 4'd7, 1'b1, 4'd7, 16'hAAAA, 2'b10);
        step();
        idle();
        repeat (LAT - 1) step();
        checkValue("collisionRd1", {16'd0, rd[31:16]}, 32'h0000AA55);
        applyStimulus(1, 1'b1, 4'd7, 1'b0, 4'd0, 16'h0, 2'b00);
        step();
        idle();
        repeat (LAT - 1) step();
        checkValue("collisionMem", {16'd0, rd[31:16]}, 32'h0000AA55);

        $display("[TB] concurrency");
        applyStimulus(0, 1'b0, 4'd0, 1'b1, 4'd2, 16'h1357, 2'b11);
        step();
        applyStimulus(0, 1'b1, 4'd2, 1'b0, 4'd0, 16'h0, 2'b00);
        applyStimulus(1, 1'b0, 4'd0, 1'b1, 4'd2, 16'hFFFF, 2'b11);
        step();
        idle();
        repeat (LAT - 1) step();
        checkValue("concRd0", {16'd0, rd[15:0]}, 32'h00001357);
        applyStimulus(1, 1'b1, 4'd2, 1'b0, 4'd0, 16'h0, 2'b00);
        step();
        idle();
        repeat (LAT - 1) step();
        checkValue("concRd1", {16'd0, rd[31:16]}, 32'h0000FFFF);

        $display("[TB] mid-operation reset");
        applyStimulus(0, 1'b1, 4'd3, 1'b0, 4'd0, 16'h0, 2'b00);
        step();
        idle();
        rst_n = 1'b0;
        step();
        checkValue("abortRvalid", {30'd0, rvalid}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checkValue("noLatePulse", {30'd0, rvalid}, 32'd0);
        end
        repeat (6) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        waitClear("restartClear");
        applyStimulus(0, 1'b1, 4'd3, 1'b0, 4'd0, 16'h0, 2'b00);
        step();
        idle();
        repeat (LAT - 1) step();
        checkValue("reclearedMem", {16'd0, rd[15:0]}, 32'h0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            for (int c = 0; c < NCH; c++) begin
                applyStimulus(c, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15) & (k[5] ? 3 : 15)),
                              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15) & (k[5] ? 3 : 15)),
                              16'($urandom), 2'($urandom_range(0, 3)));
            end
            step();
        end
        rst_n = 1'b1;
        idle();
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
